// File: rtl/uart_mensah.sv
// rtl/uart_mensah.sv - full-duplex 8N1 UART with oversampling receiver and FIFO-backed RX/TX paths.
// The RX FIFO is a capture buffer: it only fills, and out shows its oldest byte.
module uart_mensah #(
  parameter int OVERSAMPLE = 16,
  parameter int TICK_DIV   = 1,
  parameter int FIFO_DEPTH = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxEnabled,
  input  logic       rx,
  output logic       rx_empty,
  output logic       rxBusy,
  output logic       rxErr,
  output logic [7:0] out,
  output logic       full,
  input  logic [7:0] in,
  input  logic       wr_uart,
  output logic       tx_full,
  output logic       tx,
  output logic       txBusy,
  output logic       txErr
);
  localparam int OW = $clog2(OVERSAMPLE);
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int BW = $clog2(OVERSAMPLE * TICK_DIV);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [OW-1:0] OS_LAST   = OW'(OVERSAMPLE - 1);
  localparam logic [OW-1:0] OS_HALF   = OW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(OVERSAMPLE * TICK_DIV - 1);
  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_state_t;

  logic [TW-1:0] tick_cnt_q;
  logic          tick;
  assign tick = (tick_cnt_q == TICK_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) tick_cnt_q <= '0;
    else        tick_cnt_q <= tick ? '0 : tick_cnt_q + 1'b1;
  end

  // rx_prev_q trails the synchronised line by one clock for falling-edge detection
  logic rx_s1_q, rx_s2_q, rx_prev_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_s1_q   <= rx;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
    end
  end

  uart_state_t   rx_state_q, rx_state_d;
  logic [OW-1:0] rx_os_q, rx_os_d;
  logic [2:0]    rx_bit_q, rx_bit_d;
  logic [7:0]    rx_sh_q, rx_sh_d;
  logic          rx_done;

  always_comb begin
    rx_state_d = rx_state_q;
    rx_os_d    = rx_os_q;
    rx_bit_d   = rx_bit_q;
    rx_sh_d    = rx_sh_q;
    rx_done    = 1'b0;
    if (!rxEnabled) begin
      rx_state_d = S_IDLE;
      rx_os_d    = '0;
    end else begin
      case (rx_state_q)
        S_IDLE: if (rx_prev_q && !rx_s2_q) begin
          rx_state_d = S_START;
          rx_os_d    = '0;
        end
        S_START: if (tick) begin
          if (rx_os_q == OS_HALF) begin
            rx_state_d = rx_s2_q ? S_IDLE : S_DATA;
            rx_os_d    = '0;
            rx_bit_d   = '0;
          end else rx_os_d = rx_os_q + 1'b1;
        end
        S_DATA: if (tick) begin
          if (rx_os_q == OS_LAST) begin
            rx_sh_d = {rx_s2_q, rx_sh_q[7:1]};
            rx_os_d = '0;
            if (rx_bit_q == 3'd7) rx_state_d = S_STOP;
            else                  rx_bit_d   = rx_bit_q + 1'b1;
          end else rx_os_d = rx_os_q + 1'b1;
        end
        default: if (tick) begin
          if (rx_os_q == OS_LAST) begin
            rx_done    = 1'b1;
            rx_state_d = S_IDLE;
            rx_os_d    = '0;
          end else rx_os_d = rx_os_q + 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_state_q <= S_IDLE;
      rx_os_q    <= '0;
      rx_bit_q   <= '0;
      rx_sh_q    <= '0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_os_q    <= rx_os_d;
      rx_bit_q   <= rx_bit_d;
      rx_sh_q    <= rx_sh_d;
    end
  end

  logic [7:0]    rx_mem_q [FIFO_DEPTH];
  logic [AW-1:0] rx_wptr_q;
  logic [CW-1:0] rx_cnt_q;
  logic [7:0]    out_q;
  logic          rx_err_q;
  logic          rx_push;

  assign full     = (rx_cnt_q == DEPTH_C);
  assign rx_empty = (rx_cnt_q == '0);
  assign rx_push  = rx_done && rx_s2_q && !full;
  assign rxBusy   = (rx_state_q != S_IDLE);
  assign rxErr    = rx_err_q;
  assign out      = out_q;

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem_q[rx_wptr_q] <= rx_sh_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_wptr_q <= '0;
      rx_cnt_q  <= '0;
      out_q     <= '0;
      rx_err_q  <= 1'b0;
    end else begin
      rx_err_q <= rx_done && (!rx_s2_q || full);
      if (rx_push) begin
        rx_wptr_q <= rx_wptr_q + 1'b1;
        rx_cnt_q  <= rx_cnt_q + 1'b1;
      end
      if (rx_push && rx_empty) out_q <= rx_sh_q;
      else if (!rx_empty)      out_q <= rx_mem_q[0];
    end
  end

  logic [7:0]    tx_mem_q [FIFO_DEPTH];
  logic [AW-1:0] tx_wptr_q, tx_rptr_q;
  logic [CW-1:0] tx_cnt_q;
  logic          tx_push, tx_pop, tx_fifo_empty, tx_err_q;

  assign tx_full       = (tx_cnt_q == DEPTH_C);
  assign tx_fifo_empty = (tx_cnt_q == '0);
  assign tx_push       = wr_uart && !tx_full;
  assign txErr         = tx_err_q;

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem_q[tx_wptr_q] <= in;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_wptr_q <= '0;
      tx_rptr_q <= '0;
      tx_cnt_q  <= '0;
      tx_err_q  <= 1'b0;
    end else begin
      tx_err_q <= wr_uart && tx_full;
      if (tx_push) tx_wptr_q <= tx_wptr_q + 1'b1;
      if (tx_pop)  tx_rptr_q <= tx_rptr_q + 1'b1;
      if (tx_push && !tx_pop)      tx_cnt_q <= tx_cnt_q + 1'b1;
      else if (!tx_push && tx_pop) tx_cnt_q <= tx_cnt_q - 1'b1;
    end
  end

  // TX times bits in whole clocks so every bit is exactly OVERSAMPLE*TICK_DIV wide
  uart_state_t   tx_state_q, tx_state_d;
  logic [BW-1:0] tx_clk_q, tx_clk_d;
  logic [2:0]    tx_bit_q, tx_bit_d;
  logic [7:0]    tx_sh_q, tx_sh_d;
  logic          tx_q, tx_d;

  assign tx     = tx_q;
  assign txBusy = (tx_state_q != S_IDLE);

  always_comb begin
    tx_state_d = tx_state_q;
    tx_clk_d   = tx_clk_q;
    tx_bit_d   = tx_bit_q;
    tx_sh_d    = tx_sh_q;
    tx_d       = tx_q;
    tx_pop     = 1'b0;
    case (tx_state_q)
      S_IDLE: if (!tx_fifo_empty) begin
        tx_pop     = 1'b1;
        tx_sh_d    = tx_mem_q[tx_rptr_q];
        tx_state_d = S_START;
        tx_clk_d   = '0;
        tx_d       = 1'b0;
      end
      S_START: if (tx_clk_q == BIT_LAST) begin
        tx_state_d = S_DATA;
        tx_clk_d   = '0;
        tx_bit_d   = '0;
        tx_d       = tx_sh_q[0];
      end else tx_clk_d = tx_clk_q + 1'b1;
      S_DATA: if (tx_clk_q == BIT_LAST) begin
        tx_clk_d = '0;
        if (tx_bit_q == 3'd7) begin
          tx_state_d = S_STOP;
          tx_d       = 1'b1;
        end else begin
          tx_bit_d = tx_bit_q + 1'b1;
          tx_sh_d  = {1'b0, tx_sh_q[7:1]};
          tx_d     = tx_sh_q[1];
        end
      end else tx_clk_d = tx_clk_q + 1'b1;
      default: if (tx_clk_q == BIT_LAST) begin
        tx_clk_d = '0;
        if (!tx_fifo_empty) begin
          tx_pop     = 1'b1;
          tx_sh_d    = tx_mem_q[tx_rptr_q];
          tx_state_d = S_START;
          tx_d       = 1'b0;
        end else tx_state_d = S_IDLE;
      end else tx_clk_d = tx_clk_q + 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_state_q <= S_IDLE;
      tx_clk_q   <= '0;
      tx_bit_q   <= '0;
      tx_sh_q    <= '0;
      tx_q       <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_clk_q   <= tx_clk_d;
      tx_bit_q   <= tx_bit_d;
      tx_sh_q    <= tx_sh_d;
      tx_q       <= tx_d;
    end
  end
endmodule

// File: tb/tb_uart_mensah.sv
// tb/tb_uart_mensah.sv - directed vectors for uart_mensah RX capture and TX framing.
module tb_uart_mensah;
  logic       clk = 1'b0;
  logic       reset, rxEnabled, rx, wr_uart;
  logic [7:0] in;
  logic       rx_empty, rxBusy, rxErr, full, tx_full, tx, txBusy, txErr;
  logic [7:0] out;

  always #5 clk = ~clk;

  uart_mensah dut (
    .clk(clk), .reset(reset), .rxEnabled(rxEnabled), .rx(rx),
    .rx_empty(rx_empty), .rxBusy(rxBusy), .rxErr(rxErr), .out(out), .full(full),
    .in(in), .wr_uart(wr_uart), .tx_full(tx_full), .tx(tx), .txBusy(txBusy), .txErr(txErr)
  );

  int compared = 0;
  int mismatched = 0;
  int rx_err_cnt = 0;
  int tx_err_cnt = 0;
  int tx_full_cnt = 0;

  always @(negedge clk) begin
    if (rxErr)   rx_err_cnt++;
    if (txErr)   tx_err_cnt++;
    if (tx_full) tx_full_cnt++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_rx(input logic [7:0] b, input bit stop, output bit busy_mid);
    busy_mid = 1'b0;
    rx = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      if (i == 4) begin
        repeat (8) @(negedge clk);
        busy_mid = rxBusy;
        repeat (8) @(negedge clk);
      end else repeat (16) @(negedge clk);
    end
    rx = stop;
    repeat (16) @(negedge clk);
    if (!stop) begin
      rx = 1'b1;
      repeat (16) @(negedge clk);
    end
  endtask

  typedef struct {
    logic [7:0] data;
    bit         stop;
    int         err;
    bit         empty;
    bit         full;
    logic [7:0] outv;
  } rx_vec_t;

  rx_vec_t    vecs [10];
  logic [7:0] tx_bytes [11];
  bit         txs [1600];
  bit         busys [1600];

  initial begin
    bit         busy_mid;
    int         e0, f0, s, cnt;
    logic [9:0] frame, got;

    vecs[0] = '{8'h33, 1'b0, 1, 1'b1, 1'b0, 8'h00};
    vecs[1] = '{8'hA5, 1'b1, 0, 1'b0, 1'b0, 8'hA5};
    vecs[2] = '{8'h5A, 1'b1, 0, 1'b0, 1'b0, 8'hA5};
    vecs[3] = '{8'hFF, 1'b1, 0, 1'b0, 1'b0, 8'hA5};
    vecs[4] = '{8'h00, 1'b1, 0, 1'b0, 1'b0, 8'hA5};
    vecs[5] = '{8'h12, 1'b1, 0, 1'b0, 1'b0, 8'hA5};
    vecs[6] = '{8'h34, 1'b1, 0, 1'b0, 1'b0, 8'hA5};
    vecs[7] = '{8'h56, 1'b1, 0, 1'b0, 1'b0, 8'hA5};
    vecs[8] = '{8'h78, 1'b1, 0, 1'b0, 1'b1, 8'hA5};
    vecs[9] = '{8'h9C, 1'b1, 1, 1'b0, 1'b1, 8'hA5};
    tx_bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h99, 8'hAA, 8'hBB};

    reset = 1'b0; rxEnabled = 1'b0; rx = 1'b1; wr_uart = 1'b0; in = 8'h00;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_tx", tx, 1);
    chk("reset_rx_empty", rx_empty, 1);
    chk("reset_full", full, 0);
    chk("reset_tx_full", tx_full, 0);
    chk("reset_out", out, 8'h00);
    chk("reset_flags", {rxBusy, txBusy, rxErr, txErr}, 4'b0000);

    rxEnabled = 1'b1;
    repeat (4) @(negedge clk);

    // 4-clock glitch: busy rises, start-centre sample sees high, abort silently
    e0 = rx_err_cnt;
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (2) @(negedge clk);
    chk("glitch_busy_seen", rxBusy, 1);
    repeat (30) @(negedge clk);
    chk("glitch_busy_end", rxBusy, 0);
    chk("glitch_no_err", rx_err_cnt - e0, 0);
    chk("glitch_no_push", rx_empty, 1);

    for (int i = 0; i < 10; i++) begin
      e0 = rx_err_cnt;
      send_rx(vecs[i].data, vecs[i].stop, busy_mid);
      chk($sformatf("rx%0d_busy_mid", i), busy_mid, 1);
      chk($sformatf("rx%0d_busy_end", i), rxBusy, 0);
      chk($sformatf("rx%0d_err", i), rx_err_cnt - e0, vecs[i].err);
      chk($sformatf("rx%0d_empty", i), rx_empty, vecs[i].empty);
      chk($sformatf("rx%0d_full", i), full, vecs[i].full);
      chk($sformatf("rx%0d_out", i), out, vecs[i].outv);
    end

    // single TX frame of 0x3C, sampled every clock
    wr_uart = 1'b1;
    in = 8'h3C;
    for (int i = 0; i < 180; i++) begin
      @(negedge clk);
      wr_uart = 1'b0;
      txs[i] = tx;
      busys[i] = txBusy;
    end
    chk("tx1_idle_before", txs[0], 1);
    frame = {1'b1, 8'h3C, 1'b0};
    for (int k = 0; k < 10; k++) begin
      cnt = 0;
      for (int j = 0; j < 16; j++) if (txs[1 + 16*k + j] == frame[k]) cnt++;
      chk($sformatf("tx1_bit%0d_width", k), cnt, 16);
    end
    cnt = 0;
    for (int i = 0; i < 180; i++) if (busys[i]) cnt++;
    chk("tx1_busy_clocks", cnt, 160);
    chk("tx1_busy_start", busys[1], 1);

    // 11 consecutive writes: first one pops early, 9 accepted, last 2 rejected
    e0 = tx_err_cnt;
    f0 = tx_full_cnt;
    fork
      begin
        for (int i = 0; i < 11; i++) begin
          wr_uart = 1'b1;
          in = tx_bytes[i];
          @(negedge clk);
        end
        wr_uart = 1'b0;
      end
      begin
        for (int i = 0; i < 1600; i++) begin
          @(negedge clk);
          txs[i] = tx;
          busys[i] = txBusy;
        end
      end
    join
    s = -1;
    for (int i = 0; i < 50; i++) if (s < 0 && !txs[i]) s = i;
    chk("tx2_start_index", s, 1);
    if (s < 0) s = 1;
    for (int f = 0; f < 9; f++) begin
      for (int k = 0; k < 10; k++) got[k] = txs[s + 160*f + 16*k + 8];
      chk($sformatf("tx2_frame%0d", f), got, {1'b1, tx_bytes[f], 1'b0});
    end
    cnt = 0;
    for (int i = 0; i < 1440; i++) if (busys[s + i]) cnt++;
    chk("tx2_back_to_back_busy", cnt, 1440);
    chk("tx2_idle_after", {busys[s + 1440], txs[s + 1440]}, 2'b01);
    chk("tx2_err_pulses", tx_err_cnt - e0, 2);
    chk("tx2_full_seen", (tx_full_cnt - f0) > 0, 1);
    chk("tx2_full_cleared", tx_full, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
